// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the word-addressed PC, drives the combinational
// instruction memory and buffers fetched {PC+1, instruction} pairs in a small
// FIFO so fetch can run ahead while ID stalls. A redirect flushes the queue and
// restarts fetch at the target.
module if_fetch_queue #(
    parameter int unsigned       ADDR_W   = 30,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h0000_0C00
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        im_addr,
    input  logic [DATA_W-1:0]        im_rdata,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_instr,
    output logic [ADDR_W-1:0]        id_pc_add_one,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage is deliberately left out of reset; count_q gates its use.
    logic [ADDR_W-1:0] pc1_mem   [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic              full;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] pc_inc;

    // Handshake decode and incremented PC (wraps modulo 2^ADDR_W)
    always_comb begin
        pc_inc   = pc_q + ADDR_W'(1);
        full     = (count_q == CNT_W'(DEPTH));
        id_valid = (count_q != '0);
        pop      = id_valid & id_ready;
        // A full queue may still accept a push when the head is leaving.
        push     = fetch_en & ~redirect_valid & (~full | pop);
    end

    // Next-state: redirect overrides push/pop bookkeeping
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_inc;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // PC, pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue write port
    always_ff @(posedge clk) begin
        if (push) begin
            pc1_mem[wr_ptr_q]   <= pc_inc;
            instr_mem[wr_ptr_q] <= im_rdata;
        end
    end

    // Head entry presented to ID; NOP and zero PC+1 when empty
    always_comb begin
        id_instr      = '0;
        id_pc_add_one = '0;
        if (id_valid) begin
            id_instr      = instr_mem[rd_ptr_q];
            id_pc_add_one = pc1_mem[rd_ptr_q];
        end
    end

    assign im_addr = pc_q;
    assign q_count = count_q;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS core; replaces the bare PC register, PC mux and IF/ID register.
- Owns the word-addressed PC and drives the combinational instruction memory.
- Buffers fetched {PC+1, instruction} pairs in a DEPTH-entry FIFO, so IF keeps fetching while ID stalls on load-use hazards.
- Redirects (branch/jump resolved in ID) flush the queue and restart fetch at the target.

Parameters:
- ADDR_W, 30, word-address width (PC bits [31:2]).
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, legal range 2..16.
- RESET_PC, 30'h0000_0C00, word address fetched after reset (byte address 0x3000).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- im_addr  out  ADDR_W  word address to instruction memory; equals the PC register.
- im_rdata  in  DATA_W  instruction at im_addr, valid in the same cycle (combinational memory).
- fetch_en  in  1  global fetch enable; 0 freezes the PC and blocks pushes, but pops still occur.
- redirect_valid  in  1  branch/jump taken in ID this cycle.
- redirect_pc  in  ADDR_W  target word address.
- id_ready  in  1  ID consumes the head entry this cycle (0 = load-use stall).
- id_valid  out  1  head entry present.
- id_instr  out  DATA_W  head instruction; 0 (NOP) when empty.
- id_pc_add_one  out  ADDR_W  head PC+1; 0 when empty.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC, rd_ptr=wr_ptr=0, q_count=0, id_valid=0, id_instr=0, id_pc_add_one=0. Queue storage is not cleared.
- Signals:
  - pop = id_valid & id_ready.
  - full = (q_count==DEPTH).
  - push = fetch_en & ~redirect_valid & (~full | pop).
- On push: write {PC+1, im_rdata} at wr_ptr; PC <= PC+1; wr_ptr increments.
- On pop: rd_ptr increments.
- q_count update: q_count <= q_count + push - pop.
- Latency: an instruction fetched in cycle t appears on id_* in cycle t+1 at the earliest, when the queue was empty or was drained to that entry.
- Full with pop in the same cycle: push is allowed; occupancy stays at DEPTH; the PC advances.
- Full without pop: no push; PC and im_addr hold.
- Empty: id_valid=0; id_instr and id_pc_add_one read 0; id_ready is ignored.
- Redirect (has priority over everything except reset):
  - At the edge: PC <= redirect_pc, rd_ptr=wr_ptr=0, q_count=0; no push that cycle.
  - A simultaneous pop is still accepted by ID in that cycle (the head is the branch delay-free successor and is discarded by the flush).
  - In the following cycle id_valid=0 and im_addr=redirect_pc.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: PC holds and there is no push. Pops drain the queue. Redirect still loads the PC and flushes.
- Arithmetic:
  - PC+1 wraps modulo 2^ADDR_W (30'h3FFF_FFFF+1 = 0).
  - Pointers wrap modulo DEPTH.
  - q_count never exceeds DEPTH and never underflows.
- Outputs id_* are driven directly from the head entry (registered storage); there is no combinational path from im_rdata to id_*.
- Reset asserted mid-operation: immediate return to the reset state. After release, the first fetch is at RESET_PC on the first rising edge with rst=1.

Test Plan:
- Reset release, id_ready=1, memory holds word N at address N: cycle 1 im_addr=0x0C00; cycle 2 id_valid=1, id_instr=mem[0x0C00], id_pc_add_one=0x0C01; one instruction per cycle thereafter.
- id_ready=0 for 6 cycles (DEPTH=4): q_count goes 1,2,3,4,4,4; im_addr stops at 0x0C04. On release, entries 0x0C00..0x0C03 are popped in order with no gaps and fetch resumes at 0x0C04.
- Redirect to 0x0100 while q_count=3: next cycle q_count=0, id_valid=0, im_addr=0x0100; the cycle after, id_pc_add_one=0x0101.
- Full queue with id_ready=1 and fetch_en=1: q_count stays at 4 and the PC increments every cycle (simultaneous push/pop).
- PC=30'h3FFF_FFFF, push: id_pc_add_one=0 and next im_addr=0 (wrap).
- rst pulsed low asynchronously mid-fill (q_count=2): outputs clear immediately without a clock edge; after release, refetch starts from 0x0C00.
